booth_ctrl: RTL and testbench
=============================

// Module: booth_ctrl
// PURPOSE
// Control unit for the radix-2 Booth sequential multiplier. Sequences the A/Q/M datapath registers:
// loads operands, runs WIDTH test/add-sub/shift iterations, then drives A and Q onto the output bus.
// Inputs are the Q[0]/Q[-1] status bits; outputs are per-cycle register command strobes.
// Sits beside the A, Q and M registers and the adder/subtractor, and is the only source of their controls.
// PARAMETERS
// WIDTH   8               operand width = iteration count
// CNT_W   $clog2(WIDTH)   iteration counter width
// PORTS
// clk     in   1   clock, rising edge
// rst_b   in   1   reset, asynchronous, active-low
// start   in   1   begin operation; sampled only in IDLE
// q0      in   1   Q[0] from Q register
// q_m1    in   1   Q[-1] Booth extra bit
// clr_a   out  1   clear A and Q[-1]
// ld_m    out  1   load M from input bus
// ld_q    out  1   load Q from input bus
// ld_sum  out  1   load adder output into A
// sub     out  1   adder mode: 1 = A-M, 0 = A+M; valid while ld_sum=1, else 0
// sh_r    out  1   arithmetic shift right of A:Q:Q[-1]
// oe_a    out  1   drive A onto output bus
// oe_q    out  1   drive Q onto output bus
// ready   out  1   high in IDLE only
// done    out  1   one-cycle pulse, coincides with oe_q
// BEHAVIOUR
// - Reset: state IDLE, counter 0; all strobes 0, ready=1, done=0.
// - Moore outputs, decoded from the state register only. At most one of ld_sum/sh_r/ld_m/ld_q is active per cycle.
// - States and transitions:
//   IDLE   : ready=1. start=1 -> LD_M, else stay.
//   LD_M   : ld_m=1, clr_a=1; counter<=0 -> LD_Q.
//   LD_Q   : ld_q=1 -> TEST.
//   TEST   : no strobes. {q0,q_m1}=01 -> ADD(sub=0); 10 -> ADD(sub=1); 00/11 -> SHIFT.
//   ADD    : ld_sum=1, sub as latched in TEST -> SHIFT.
//   SHIFT  : sh_r=1. counter==WIDTH-1 -> OUT_A; else counter+1 -> TEST.
//   OUT_A  : oe_a=1 -> OUT_Q.
//   OUT_Q  : oe_q=1, done=1 -> IDLE.
// - The sub mode bit is registered on the TEST->ADD transition; q0/q_m1 are ignored outside TEST.
// - Latency (edge that samples start = cycle 0): LD_M in cycle 1, LD_Q in cycle 2, iterations from cycle 3.
//   Each iteration is 2 cycles (no op) or 3 cycles (add/sub).
//   done in cycle 2+2*WIDTH+k+2, where k = number of add/sub iterations: 20..28 for WIDTH=8.
// - Exactly WIDTH sh_r pulses per operation; the counter never wraps within an operation.
// - start while busy (not IDLE) is ignored. start still high on return to IDLE starts a new operation:
//   LD_M one cycle after ready rises.
// - rst_b low at any time returns immediately to the reset state; an operation in flight is abandoned.
//   No done is issued for it.
// TESTING
// - Reset: assert rst_b=0 mid-ADD -> all strobes 0 and ready=1 at once; after release, idle until start.
// - q0=q_m1=0 constant, start pulse -> 8 sh_r, 0 ld_sum, oe_a in cycle 19, done in cycle 20.
// - {q0,q_m1}=01 constant -> 8 ld_sum with sub=0, each followed by sh_r; done in cycle 28.
// - {q0,q_m1}=10 constant -> 8 ld_sum with sub=1; done in cycle 28.
// - With datapath model, M=8'h07, Q=8'hFD (-3) -> A:Q = 16'hFFEB (-21) read on oe_a/oe_q.
// - start pulsed during SHIFT is ignored. start held high -> two back-to-back operations, ready high for 1 cycle between them.

Source files
------------

// File: rtl/booth_ctrl_if.sv
// Command/status bundle between the Booth controller and its A/Q/M datapath.
// The slave side is the controller; the master side is whoever requests and feeds status.
interface booth_ctrl_if;
   logic start;
   logic q0;
   logic q_m1;
   logic clr_a;
   logic ld_m;
   logic ld_q;
   logic ld_sum;
   logic sub;
   logic sh_r;
   logic oe_a;
   logic oe_q;
   logic ready;
   logic done;

   modport master (
      output start, q0, q_m1,
      input  clr_a, ld_m, ld_q, ld_sum, sub, sh_r, oe_a, oe_q, ready, done
   );

   modport slave (
      input  start, q0, q_m1,
      output clr_a, ld_m, ld_q, ld_sum, sub, sh_r, oe_a, oe_q, ready, done
   );
endinterface

// File: rtl/booth_ctrl.sv
// Radix-2 Booth sequential multiplier control unit: sequences operand load,
// WIDTH test/add-sub/shift iterations and the two-cycle result readout.
module booth_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input logic         clk,
   input logic         rst_b,
   booth_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_M,
      S_LD_Q,
      S_TEST,
      S_ADD,
      S_SHIFT,
      S_OUT_A,
      S_OUT_Q
   } state_t;

   typedef struct packed {
      logic clr_a;
      logic ld_m;
      logic ld_q;
      logic ld_sum;
      logic sub;
      logic sh_r;
      logic oe_a;
      logic oe_q;
      logic ready;
      logic done;
   } strobes_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   strobes_t         strb_q, strb_d;

   // Outputs are a pure decode of the state; registering the decode of the
   // next state keeps them Moore while coming straight from flops.
   function automatic strobes_t decode(input state_t s, input logic mode);
      strobes_t o;
      o = '0;
      case (s)
         S_IDLE:  o.ready  = 1'b1;
         S_LD_M:  begin o.ld_m = 1'b1; o.clr_a = 1'b1; end
         S_LD_Q:  o.ld_q   = 1'b1;
         S_ADD:   begin o.ld_sum = 1'b1; o.sub = mode; end
         S_SHIFT: o.sh_r   = 1'b1;
         S_OUT_A: o.oe_a   = 1'b1;
         S_OUT_Q: begin o.oe_q = 1'b1; o.done = 1'b1; end
         default: o = '0;
      endcase
      return o;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_LD_M;
         S_LD_M:  begin cnt_d = '0; state_d = S_LD_Q; end
         S_LD_Q:  state_d = S_TEST;
         S_TEST: begin
            // 10 -> subtract, 01 -> add, equal bits -> shift only
            if (bus.q0 != bus.q_m1) begin
               mode_d  = bus.q0;
               state_d = S_ADD;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_ADD:   state_d = S_SHIFT;
         S_SHIFT: begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_OUT_A;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_TEST;
            end
         end
         S_OUT_A: state_d = S_OUT_Q;
         S_OUT_Q: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      strb_d = decode(state_d, mode_d);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         strb_q  <= decode(S_IDLE, 1'b0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         strb_q  <= strb_d;
      end
   end

   assign bus.clr_a  = strb_q.clr_a;
   assign bus.ld_m   = strb_q.ld_m;
   assign bus.ld_q   = strb_q.ld_q;
   assign bus.ld_sum = strb_q.ld_sum;
   assign bus.sub    = strb_q.sub;
   assign bus.sh_r   = strb_q.sh_r;
   assign bus.oe_a   = strb_q.oe_a;
   assign bus.oe_q   = strb_q.oe_q;
   assign bus.ready  = strb_q.ready;
   assign bus.done   = strb_q.done;

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl with an A/Q/M datapath model for the product check.
module tb_booth_ctrl;

   logic clk;
   logic rst_b;

   booth_ctrl_if bus ();

   booth_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // status source: forced constants or the datapath model
   logic       use_model;
   logic       q0_force, qm1_force;
   logic [7:0] a_r, q_r, m_r, m_in, q_in;
   logic       qm1_r;

   assign bus.q0   = use_model ? q_r[0] : q0_force;
   assign bus.q_m1 = use_model ? qm1_r  : qm1_force;

   always @(posedge clk) begin
      if (bus.clr_a) begin a_r <= '0; qm1_r <= 1'b0; end
      if (bus.ld_m) m_r <= m_in;
      if (bus.ld_q) q_r <= q_in;
      if (bus.ld_sum) a_r <= bus.sub ? a_r - m_r : a_r + m_r;
      if (bus.sh_r) {a_r, q_r, qm1_r} <= {a_r[7], a_r, q_r};
   end

   function automatic logic [8:0] strb_vec();
      return {bus.clr_a, bus.ld_m, bus.ld_q, bus.ld_sum, bus.sub,
              bus.sh_r, bus.oe_a, bus.oe_q, bus.done};
   endfunction

   // One operation; cycle 0 is the edge that samples start.
   task automatic run_op(input int pulse_cyc, input bit hold,
                         output int n_shr, output int n_add, output int n_sub,
                         output int c_ldm, output int c_ldq, output int c_oea,
                         output int c_done, output int c_ldm2, output int n_rdy2,
                         output int n_viol, output logic [15:0] prod);
      bit fin;
      bit prev_add;
      int onehot;
      n_shr = 0; n_add = 0; n_sub = 0; c_ldm = 0; c_ldq = 0; c_oea = 0;
      c_done = 0; c_ldm2 = 0; n_rdy2 = 0; n_viol = 0; prod = '0;
      fin = 1'b0; prev_add = 1'b0;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc < 80; cyc++) begin
         @(negedge clk);
         if (!hold) bus.start = (cyc == pulse_cyc);
         if (!fin) begin
            onehot = int'(bus.ld_sum) + int'(bus.sh_r) + int'(bus.ld_m) + int'(bus.ld_q);
            if (onehot > 1) n_viol++;
            if (bus.sub && !bus.ld_sum) n_viol++;
            if (bus.oe_q != bus.done) n_viol++;
            if (bus.ready) n_viol++;
            if (prev_add && !bus.sh_r) n_viol++;
            prev_add = bus.ld_sum;
            if (bus.sh_r) n_shr++;
            if (bus.ld_sum) n_add++;
            if (bus.ld_sum && bus.sub) n_sub++;
            if (bus.ld_m && c_ldm == 0) c_ldm = cyc;
            if (bus.ld_q && c_ldq == 0) c_ldq = cyc;
            if (bus.oe_a) begin c_oea = cyc; prod[15:8] = a_r; end
            if (bus.oe_q) prod[7:0] = q_r;
            if (bus.done) begin c_done = cyc; fin = 1'b1; end
         end else begin
            if (bus.ld_m && c_ldm2 == 0) c_ldm2 = cyc;
            if (bus.ready && c_ldm2 == 0) n_rdy2++;
            if (cyc >= c_done + 3) break;
         end
      end
      bus.start = 1'b0;
   endtask

   int n_shr, n_add, n_sub, c_ldm, c_ldq, c_oea, c_done, c_ldm2, n_rdy2, n_viol;
   logic [15:0] prod;
   int bad;

   typedef struct {
      string tag;
      logic  q0;
      logic  qm1;
      int    exp_add;
      int    exp_sub;
      int    exp_done;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{"p00", 1'b0, 1'b0, 0, 0, 20};
      vecs[1] = '{"p01", 1'b0, 1'b1, 8, 0, 28};
      vecs[2] = '{"p10", 1'b1, 1'b0, 8, 8, 28};
      vecs[3] = '{"p11", 1'b1, 1'b1, 0, 0, 20};

      rst_b = 1'b0; bus.start = 1'b0; use_model = 1'b0;
      q0_force = 1'b0; qm1_force = 1'b0; m_in = '0; q_in = '0;
      @(negedge clk);
      check_eq("rst_strb", 32'(strb_vec()), 32'h0);
      check_eq("rst_rdy", 32'(bus.ready), 32'h1);
      @(negedge clk) rst_b = 1'b1;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (!bus.ready || strb_vec() != '0) bad++;
      end
      check_eq("idle_hold", 32'(bad), 32'h0);

      foreach (vecs[i]) begin
         q0_force = vecs[i].q0; qm1_force = vecs[i].qm1;
         run_op(-1, 1'b0, n_shr, n_add, n_sub, c_ldm, c_ldq, c_oea, c_done,
                c_ldm2, n_rdy2, n_viol, prod);
         check_eq({vecs[i].tag, "_shr"},  32'(n_shr), 32'd8);
         check_eq({vecs[i].tag, "_add"},  32'(n_add), 32'(vecs[i].exp_add));
         check_eq({vecs[i].tag, "_sub"},  32'(n_sub), 32'(vecs[i].exp_sub));
         check_eq({vecs[i].tag, "_ldm"},  32'(c_ldm), 32'd1);
         check_eq({vecs[i].tag, "_ldq"},  32'(c_ldq), 32'd2);
         check_eq({vecs[i].tag, "_oea"},  32'(c_oea), 32'(vecs[i].exp_done - 1));
         check_eq({vecs[i].tag, "_done"}, 32'(c_done), 32'(vecs[i].exp_done));
         check_eq({vecs[i].tag, "_prot"}, 32'(n_viol), 32'h0);
      end

      // 7 * -3 with the datapath model: recoding of 0xFD gives 3 add/sub steps
      use_model = 1'b1; m_in = 8'h07; q_in = 8'hFD;
      run_op(-1, 1'b0, n_shr, n_add, n_sub, c_ldm, c_ldq, c_oea, c_done,
             c_ldm2, n_rdy2, n_viol, prod);
      check_eq("mul_prod", 32'(prod), 32'h0000FFEB);
      check_eq("mul_add",  32'(n_add), 32'd3);
      check_eq("mul_sub",  32'(n_sub), 32'd2);
      check_eq("mul_done", 32'(c_done), 32'd23);
      check_eq("mul_prot", 32'(n_viol), 32'h0);
      use_model = 1'b0;

      // start pulsed in cycle 4 (first SHIFT) must be ignored
      q0_force = 1'b0; qm1_force = 1'b0;
      run_op(4, 1'b0, n_shr, n_add, n_sub, c_ldm, c_ldq, c_oea, c_done,
             c_ldm2, n_rdy2, n_viol, prod);
      check_eq("busy_done", 32'(c_done), 32'd20);
      check_eq("busy_ldm2", 32'(c_ldm2), 32'd0);
      check_eq("busy_rdy",  32'(n_rdy2), 32'd3);

      // start held high: back-to-back operations with one ready cycle between
      run_op(-1, 1'b1, n_shr, n_add, n_sub, c_ldm, c_ldq, c_oea, c_done,
             c_ldm2, n_rdy2, n_viol, prod);
      check_eq("hold_done", 32'(c_done), 32'd20);
      check_eq("hold_ldm2", 32'(c_ldm2), 32'd22);
      check_eq("hold_rdy",  32'(n_rdy2), 32'd1);
      @(negedge clk) rst_b = 1'b0;
      @(negedge clk) rst_b = 1'b1;

      // asynchronous reset in the middle of an ADD
      q0_force = 1'b0; qm1_force = 1'b1;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("pre_rst_add", 32'(bus.ld_sum), 32'h1);
      #1 rst_b = 1'b0;
      #1;
      check_eq("arst_strb", 32'(strb_vec()), 32'h0);
      check_eq("arst_rdy",  32'(bus.ready), 32'h1);
      @(negedge clk);
      @(negedge clk) rst_b = 1'b1;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (!bus.ready || bus.done || bus.ld_m) bad++;
      end
      check_eq("post_rst_idle", 32'(bad), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
